// File: rtl/exec_if.sv
// exec_if: issue, external-write and completion signals of the execution unit.
interface exec_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      op;
   logic            alu_src;
   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic [AW-1:0]   rd;
   logic [XLEN-1:0] imm;
   logic            ext_we;
   logic [AW-1:0]   ext_rd;
   logic [XLEN-1:0] ext_wd;
   logic            out_valid;
   logic [AW-1:0]   out_rd;
   logic [XLEN-1:0] out_result;
   logic            zero;
   logic [XLEN-1:0] write_data;
   logic [XLEN-1:0] a0;
   logic            busy;
   modport master (
      output in_valid, op, alu_src, rs1, rs2, rd, imm, ext_we, ext_rd, ext_wd,
      input  in_ready, out_valid, out_rd, out_result, zero, write_data, a0, busy
   );
   modport slave (
      input  in_valid, op, alu_src, rs1, rs2, rd, imm, ext_we, ext_rd, ext_wd,
      output in_ready, out_valid, out_rd, out_result, zero, write_data, a0, busy
   );
endinterface

// File: rtl/exec_unit.sv
// exec_unit: register file plus single-cycle ALU and iterative shift-add multiplier /
// restoring divider sharing one register write port with an external load path.
module exec_unit #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input logic   clk,
   input logic   rst_n,
   exec_if.slave bus
);
   localparam int SW = $clog2(XLEN);
   localparam int CW = $clog2(XLEN + 1);
   localparam int A0 = NREGS > 10 ? 10 : 0;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t          state, state_nx;
   logic [XLEN-1:0] regs [NREGS];
   logic [XLEN-1:0] a, rb, b, alu_y, hi, lo, dv, mc_y, wd, res_q;
   logic [AW-1:0]   mc_rd, wa, rd_q;
   logic [1:0]      mc_op;
   logic [CW-1:0]   cnt;
   logic [XLEN:0]   madd, dt;
   logic [SW-1:0]   sh;
   logic            multi, fire, single_fire, done_fire, we, dge, in_ready, valid_q, zero_q;

   assign a     = regs[bus.rs1];
   assign rb    = regs[bus.rs2];
   assign b     = bus.alu_src ? bus.imm : rb;
   assign sh    = b[SW-1:0];
   assign multi = bus.op >= 4'd10 && bus.op <= 4'd13;
   assign fire  = bus.in_valid && in_ready;
   assign single_fire = fire && !multi;

   always_comb begin
      alu_y = '0;
      case (bus.op)
         4'd0:    alu_y = a + b;
         4'd1:    alu_y = a - b;
         4'd2:    alu_y = a & b;
         4'd3:    alu_y = a | b;
         4'd4:    alu_y = a ^ b;
         4'd5:    alu_y = XLEN'($signed(a) < $signed(b));
         4'd6:    alu_y = XLEN'(a < b);
         4'd7:    alu_y = a << sh;
         4'd8:    alu_y = a >> sh;
         4'd9:    alu_y = $signed(a) >>> sh;
         default: alu_y = '0;
      endcase
   end

   // hi:lo is the product register for MUL/MULHU and remainder:quotient for DIVU/REMU
   assign madd = {1'b0, hi} + (lo[0] ? {1'b0, dv} : '0);
   assign dt   = {hi, lo[XLEN-1]};
   assign dge  = dt >= {1'b0, dv};
   assign mc_y = mc_op[0] ? hi : lo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi    <= '0;
         lo    <= '0;
         dv    <= '0;
         mc_rd <= '0;
         mc_op <= '0;
         cnt   <= '0;
      end else if (fire && multi) begin
         hi    <= '0;
         lo    <= a;
         dv    <= b;
         mc_rd <= bus.rd;
         mc_op <= bus.op[1:0];
         cnt   <= '0;
      end else if (state == RUN && cnt != CW'(XLEN)) begin
         cnt <= cnt + 1'b1;
         if (mc_op[1]) begin
            hi <= madd[XLEN:1];
            lo <= {madd[0], lo[XLEN-1:1]};
         end else begin
            hi <= dge ? XLEN'(dt - {1'b0, dv}) : dt[XLEN-1:0];
            lo <= {lo[XLEN-2:0], dge};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = fire && multi ? RUN : IDLE;
         RUN:     state_nx = cnt == CW'(XLEN) ? DONE : RUN;
         DONE:    state_nx = bus.ext_we ? DONE : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = state == IDLE && !bus.ext_we;
      done_fire = state == DONE && !bus.ext_we;
   end

   // external loads own the single write port whenever asserted
   assign we = bus.ext_we || single_fire || done_fire;
   assign wa = bus.ext_we ? bus.ext_rd : single_fire ? bus.rd : mc_rd;
   assign wd = bus.ext_we ? bus.ext_wd : single_fire ? alu_y : mc_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we && wa != '0) begin
         regs[wa] <= wd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         rd_q    <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         valid_q <= single_fire || done_fire;
         if (single_fire) begin
            rd_q   <= bus.rd;
            res_q  <= alu_y;
            zero_q <= alu_y == '0;
         end else if (done_fire) begin
            rd_q   <= mc_rd;
            res_q  <= mc_y;
            zero_q <= mc_y == '0;
         end
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.busy       = state != IDLE;
   assign bus.out_valid  = valid_q;
   assign bus.out_rd     = rd_q;
   assign bus.out_result = res_q;
   assign bus.zero       = zero_q;
   assign bus.write_data = rb;
   assign bus.a0         = regs[A0[AW-1:0]];
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed scenario tests for exec_unit with hand-computed results.
module tb_exec_unit;
   localparam int XLEN = 32;
   localparam int NREGS = 32;
   localparam int AW = 5;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   exec_if #(.XLEN(XLEN), .AW(AW)) bus ();
   exec_unit #(.XLEN(XLEN), .NREGS(NREGS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.in_valid = 0; bus.op = 0; bus.alu_src = 0; bus.rs1 = 0; bus.rs2 = 0; bus.rd = 0;
      bus.imm = 0; bus.ext_we = 0; bus.ext_rd = 0; bus.ext_wd = 0;
   endtask

   task automatic ext_write(input logic [AW-1:0] r, input logic [XLEN-1:0] d);
      bus.ext_we = 1; bus.ext_rd = r; bus.ext_wd = d;
      @(negedge clk);
      bus.ext_we = 0;
   endtask

   task automatic set_issue(input logic [3:0] op, input logic [AW-1:0] rs1, rs2, rd,
                            input logic src, input logic [XLEN-1:0] imm);
      bus.op = op; bus.rs1 = rs1; bus.rs2 = rs2; bus.rd = rd; bus.alu_src = src; bus.imm = imm;
      bus.in_valid = 1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [AW-1:0] rs1, rs2, rd,
                        input logic src, input logic [XLEN-1:0] imm);
      set_issue(op, rs1, rs2, rd, src, imm);
      @(negedge clk);
      bus.in_valid = 0;
   endtask

   task automatic read_reg(input logic [AW-1:0] r, output logic [XLEN-1:0] v);
      bus.rs2 = r;
      #1 v = bus.write_data;
   endtask

   task automatic run_multi(input logic [3:0] op, input logic [AW-1:0] rs1, rs2, rd,
                            output int busy_n, output int pulses, output logic [XLEN-1:0] res);
      issue(op, rs1, rs2, rd, 1'b0, '0);
      busy_n = 0; pulses = 0; res = '0;
      for (int i = 0; i < 50; i++) begin
         if (!bus.in_ready) busy_n++;
         if (bus.out_valid) begin pulses++; res = bus.out_result; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      #2 rst_n = 0;
      repeat (2) @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.out_result !== 32'h0) begin n_bad++; $display("FAIL rst_out_result: got %h want 0", bus.out_result); end
      n_cmp++; if (bus.zero !== 1'b0 || bus.out_rd !== 5'd0) begin n_bad++; $display("FAIL rst_zero_rd: got %b/%0d want 0/0", bus.zero, bus.out_rd); end
      n_cmp++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_state: busy %b ready %b want 0/1", bus.busy, bus.in_ready); end
      n_cmp++; if (bus.a0 !== 32'h0) begin n_bad++; $display("FAIL rst_a0: got %h want 0", bus.a0); end
      set_issue(4'd0, 5'd0, 5'd0, 5'd6, 1'b1, 32'd9);
      rst_n = 1;
      @(negedge clk);
      bus.in_valid = 0;
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd9 || bus.out_rd !== 5'd6) begin
         n_bad++; $display("FAIL first_issue: valid %b result %0d rd %0d want 1/9/6", bus.out_valid, bus.out_result, bus.out_rd); end
   endtask

   task automatic test_alu();
      logic [XLEN-1:0] v;
      ext_write(5'd1, 32'd7);
      ext_write(5'd2, 32'd5);
      issue(4'd1, 5'd1, 5'd2, 5'd3, 1'b0, '0);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd2 || bus.zero !== 1'b0 || bus.out_rd !== 5'd3) begin
         n_bad++; $display("FAIL sub: valid %b result %0d zero %b rd %0d want 1/2/0/3", bus.out_valid, bus.out_result, bus.zero, bus.out_rd); end
      read_reg(5'd3, v);
      n_cmp++; if (v !== 32'd2) begin n_bad++; $display("FAIL sub_x3: got %0d want 2", v); end
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_result !== 32'd2) begin
         n_bad++; $display("FAIL sub_hold: valid %b result %0d want 0/2", bus.out_valid, bus.out_result); end
      issue(4'd1, 5'd1, 5'd1, 5'd7, 1'b0, '0);
      n_cmp++; if (bus.out_result !== 32'd0 || bus.zero !== 1'b1) begin
         n_bad++; $display("FAIL sub_zero: result %0d zero %b want 0/1", bus.out_result, bus.zero); end
      issue(4'd3, 5'd1, 5'd2, 5'd7, 1'b0, '0);
      n_cmp++; if (bus.out_result !== 32'd7) begin n_bad++; $display("FAIL or: got %0d want 7", bus.out_result); end
      issue(4'd4, 5'd1, 5'd2, 5'd7, 1'b0, '0);
      n_cmp++; if (bus.out_result !== 32'd2) begin n_bad++; $display("FAIL xor: got %0d want 2", bus.out_result); end
   endtask

   task automatic test_shift();
      ext_write(5'd1, 32'h8000_0000);
      issue(4'd9, 5'd1, 5'd0, 5'd10, 1'b1, 32'd4);
      n_cmp++; if (bus.a0 !== 32'hF800_0000 || bus.out_result !== 32'hF800_0000) begin
         n_bad++; $display("FAIL sra: a0 %h result %h want f8000000", bus.a0, bus.out_result); end
      issue(4'd6, 5'd1, 5'd0, 5'd11, 1'b1, 32'd1);
      n_cmp++; if (bus.out_result !== 32'd0 || bus.zero !== 1'b1) begin
         n_bad++; $display("FAIL sltu: result %0d zero %b want 0/1", bus.out_result, bus.zero); end
      issue(4'd5, 5'd1, 5'd0, 5'd11, 1'b1, 32'd1);
      n_cmp++; if (bus.out_result !== 32'd1) begin n_bad++; $display("FAIL slt: got %0d want 1", bus.out_result); end
      issue(4'd7, 5'd2, 5'd0, 5'd11, 1'b1, 32'd33);
      n_cmp++; if (bus.out_result !== 32'd10) begin n_bad++; $display("FAIL sll_wrap_amount: got %0d want 10", bus.out_result); end
      issue(4'd8, 5'd1, 5'd0, 5'd11, 1'b1, 32'd4);
      n_cmp++; if (bus.out_result !== 32'h0800_0000) begin n_bad++; $display("FAIL srl: got %h want 08000000", bus.out_result); end
      issue(4'd14, 5'd1, 5'd2, 5'd11, 1'b0, '0);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd0 || bus.zero !== 1'b1) begin
         n_bad++; $display("FAIL op14: valid %b result %0d zero %b want 1/0/1", bus.out_valid, bus.out_result, bus.zero); end
   endtask

   task automatic test_mul();
      int b, p;
      logic [XLEN-1:0] r, v;
      ext_write(5'd1, 32'hFFFF_FFFF);
      ext_write(5'd2, 32'd2);
      run_multi(4'd11, 5'd1, 5'd2, 5'd4, b, p, r);
      n_cmp++; if (b !== 34) begin n_bad++; $display("FAIL mulhu_busy: got %0d want 34", b); end
      n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL mulhu_pulses: got %0d want 1", p); end
      n_cmp++; if (r !== 32'd1) begin n_bad++; $display("FAIL mulhu_result: got %h want 1", r); end
      read_reg(5'd4, v);
      n_cmp++; if (v !== 32'd1) begin n_bad++; $display("FAIL mulhu_x4: got %h want 1", v); end
      run_multi(4'd10, 5'd1, 5'd2, 5'd5, b, p, r);
      read_reg(5'd5, v);
      n_cmp++; if (r !== 32'hFFFF_FFFE || v !== 32'hFFFF_FFFE) begin
         n_bad++; $display("FAIL mul: result %h x5 %h want fffffffe", r, v); end
   endtask

   task automatic test_div();
      int b, p;
      logic [XLEN-1:0] r, v;
      ext_write(5'd1, 32'd100);
      ext_write(5'd2, 32'd0);
      run_multi(4'd12, 5'd1, 5'd2, 5'd6, b, p, r);
      n_cmp++; if (r !== 32'hFFFF_FFFF || b !== 34 || p !== 1) begin
         n_bad++; $display("FAIL divu_by0: result %h busy %0d pulses %0d want ffffffff/34/1", r, b, p); end
      run_multi(4'd13, 5'd1, 5'd2, 5'd7, b, p, r);
      n_cmp++; if (r !== 32'd100) begin n_bad++; $display("FAIL remu_by0: got %0d want 100", r); end
      ext_write(5'd2, 32'd7);
      run_multi(4'd12, 5'd1, 5'd2, 5'd6, b, p, r);
      n_cmp++; if (r !== 32'd14) begin n_bad++; $display("FAIL divu: got %0d want 14", r); end
      run_multi(4'd13, 5'd1, 5'd2, 5'd7, b, p, r);
      read_reg(5'd7, v);
      n_cmp++; if (r !== 32'd2 || v !== 32'd2) begin n_bad++; $display("FAIL remu: result %0d x7 %0d want 2", r, v); end
   endtask

   task automatic test_ext_hold();
      logic [XLEN-1:0] v;
      int pulses = 0;
      bus.ext_we = 1; bus.ext_rd = 5'd1; bus.ext_wd = 32'd6;
      #1;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL ready_during_ext: got %b want 0", bus.in_ready); end
      @(negedge clk);
      bus.ext_we = 0;
      ext_write(5'd2, 32'd7);
      issue(4'd10, 5'd1, 5'd2, 5'd8, 1'b0, '0);
      repeat (33) @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_bad++; $display("FAIL done_reached: busy %b valid %b want 1/0", bus.busy, bus.out_valid); end
      bus.ext_we = 1; bus.ext_rd = 5'd8; bus.ext_wd = 32'h55;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.out_valid) pulses++;
      end
      n_cmp++; if (pulses !== 0 || bus.busy !== 1'b1) begin
         n_bad++; $display("FAIL done_held: pulses %0d busy %b want 0/1", pulses, bus.busy); end
      read_reg(5'd8, v);
      n_cmp++; if (v !== 32'h55) begin n_bad++; $display("FAIL ext_first: x8 %h want 55", v); end
      bus.ext_we = 0;
      @(negedge clk);
      read_reg(5'd8, v);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd42 || bus.out_rd !== 5'd8 || v !== 32'd42) begin
         n_bad++; $display("FAIL done_after_ext: valid %b result %0d rd %0d x8 %0d want 1/42/8/42", bus.out_valid, bus.out_result, bus.out_rd, v); end
   endtask

   task automatic test_reset_mid_run();
      logic [XLEN-1:0] v;
      int pulses = 0;
      issue(4'd10, 5'd1, 5'd2, 5'd9, 1'b0, '0);
      repeat (10) @(negedge clk);
      rst_n = 0;
      #1;
      n_cmp++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_bad++; $display("FAIL abort_state: busy %b ready %b valid %b want 0/1/0", bus.busy, bus.in_ready, bus.out_valid); end
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid) pulses++;
         @(negedge clk);
      end
      read_reg(5'd9, v);
      n_cmp++; if (pulses !== 0 || v !== 32'd0) begin n_bad++; $display("FAIL abort_result: pulses %0d x9 %0d want 0/0", pulses, v); end
      issue(4'd0, 5'd0, 5'd0, 5'd0, 1'b1, 32'd5);
      read_reg(5'd0, v);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd5 || bus.out_rd !== 5'd0 || v !== 32'd0) begin
         n_bad++; $display("FAIL rd0: valid %b result %0d rd %0d x0 %0d want 1/5/0/0", bus.out_valid, bus.out_result, bus.out_rd, v); end
   endtask

   task automatic test_back_to_back();
      logic [XLEN-1:0] v;
      set_issue(4'd0, 5'd0, 5'd0, 5'd12, 1'b1, 32'd3);
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd3) begin
         n_bad++; $display("FAIL b2b_first: valid %b result %0d want 1/3", bus.out_valid, bus.out_result); end
      set_issue(4'd0, 5'd12, 5'd0, 5'd12, 1'b1, 32'd1);
      @(negedge clk);
      bus.in_valid = 0;
      read_reg(5'd12, v);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd4 || v !== 32'd4) begin
         n_bad++; $display("FAIL b2b_second: valid %b result %0d x12 %0d want 1/4/4", bus.out_valid, bus.out_result, v); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_shift();
      test_mul();
      test_div();
      test_ext_hold();
      test_reset_mid_run();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
